// File: rtl/uart_rxfifo_pkg.sv
// uart_rxfifo_pkg: shared definitions for the UART receive FIFO slave.
//   - register word offsets within the mmapper window
//   - STATUS / CTRL bit positions
//   - RXFIFO_IRQ_EN_DEFAULT: 1 when the build defines RXFIFO_IRQ_EN
//     (threshold/irq_en registers and the irq output), 0 otherwise.
package uart_rxfifo_pkg;

  localparam logic [2:0] RXFIFO_DATA   = 3'd0;
  localparam logic [2:0] RXFIFO_STATUS = 3'd1;
  localparam logic [2:0] RXFIFO_CTRL   = 3'd2;

  // DATA register
  localparam int DATA_VALID_BIT = 8;

  // STATUS register
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVR_BIT   = 2;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_MSB   = 15;

  // CTRL register
  localparam int CTRL_THR_LSB   = 0;
  localparam int CTRL_THR_MSB   = 7;
  localparam int CTRL_IRQEN_BIT = 8;
  localparam int CTRL_FLUSH_BIT = 9;

`ifdef RXFIFO_IRQ_EN
  localparam bit RXFIFO_IRQ_EN_DEFAULT = 1'b1;
`else
  localparam bit RXFIFO_IRQ_EN_DEFAULT = 1'b0;
`endif

endpackage

// File: rtl/uart_rxfifo_mem.sv
// rxfifo_mem: 2**DEPTH_LOG2 x 8 byte storage for the UART receive FIFO.
// Ports:
//   clk    in   clock
//   wen    in   write enable (synchronous write)
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address (asynchronous read)
//   rdata  out  byte at raddr
// Contents are intentionally not reset; the owner masks stale data by count.
module rxfifo_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rxfifo.sv
// uart_rxfifo: receive byte FIFO between the uart core and the mmapper.
// Optional feature macro: RXFIFO_IRQ_EN (threshold/irq_en registers and irq).
// Without it irq is tied low and CTRL[8:0] read 0; flush still works.
// Ports:
//   clk     in   main clock
//   rstn    in   asynchronous reset, active-low
//   rxdata  in   received byte, valid while rxnew is high
//   rxnew   in   one-cycle byte strobe from the uart core
//   a       in   word offset (0 DATA, 1 STATUS, 2 CTRL)
//   d       in   write data
//   we      in   write enable
//   rd      in   read strobe; a rising edge at a=DATA pops one byte
//   spo     out  combinational read data
//   irq     out  registered level interrupt
module uart_rxfifo
  import uart_rxfifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rxdata,
  input  logic        rxnew,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        irq
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  overrun;
  logic                  rd_q;
  logic [7:0]            head_byte;
  logic [31:0]           ctrl_rd;

  logic empty, full;
  logic sel_data, sel_status, sel_ctrl;
  logic pop, push, flush, ovr_set, ovr_clr;

  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign sel_data   = (a == RXFIFO_DATA);
  assign sel_status = (a == RXFIFO_STATUS);
  assign sel_ctrl   = (a == RXFIFO_CTRL);

  // rd is a level from the mmapper; only its rising edge pops.
  assign pop     = rd & ~rd_q & sel_data & ~empty;
  assign flush   = we & sel_ctrl & d[CTRL_FLUSH_BIT];
  // A push into a full FIFO is still accepted when a pop frees the slot in
  // the same cycle; flush overrides both and drops the incoming byte.
  assign push    = rxnew & ~flush & (~full | pop);
  assign ovr_set = rxnew & ~flush & full & ~pop;
  assign ovr_clr = we & sel_status & d[STAT_OVR_BIT];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      rd_q  <= rd;
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // Setting has priority over a simultaneous write-1-to-clear.
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  rxfifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .wen   (push),
    .waddr (wr_ptr),
    .wdata (rxdata),
    .raddr (rd_ptr),
    .rdata (head_byte)
  );

`ifdef RXFIFO_IRQ_EN
  logic [7:0] threshold;
  logic       irq_en;
  logic       unused_d;

  assign unused_d = ^d[31:10];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      threshold <= '0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (we & sel_ctrl) begin
        threshold <= d[CTRL_THR_MSB:CTRL_THR_LSB];
        irq_en    <= d[CTRL_IRQEN_BIT];
      end
      // Built from registered state, so irq trails the change by one cycle.
      irq <= irq_en & (overrun |
                       ((threshold != 8'd0) && (32'(count) >= 32'(threshold))));
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_THR_MSB:CTRL_THR_LSB] = threshold;
    ctrl_rd[CTRL_IRQEN_BIT]            = irq_en;
  end
`else
  logic unused_d;

  assign unused_d = ^{d[31:10], d[8:3], d[1:0]};
  assign irq      = 1'b0;
  assign ctrl_rd  = '0;
`endif

  always_comb begin
    spo = '0;
    case (a)
      RXFIFO_DATA: begin
        spo[DATA_VALID_BIT] = ~empty;
        spo[7:0]            = empty ? 8'h00 : head_byte;
      end
      RXFIFO_STATUS: begin
        spo[STAT_CNT_MSB:STAT_CNT_LSB] = 8'(count);
        spo[STAT_OVR_BIT]              = overrun;
        spo[STAT_FULL_BIT]             = full;
        spo[STAT_EMPTY_BIT]            = empty;
      end
      RXFIFO_CTRL: spo = ctrl_rd;
      default:     spo = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rxfifo.sv
// tb_uart_rxfifo: directed self-checking bench for uart_rxfifo.
module tb_uart_rxfifo;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rxdata = '0;
  logic        rxnew = 1'b0;
  logic [2:0]  a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] spo;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rxfifo #(.DEPTH_LOG2(4)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rxdata (rxdata),
    .rxnew  (rxnew),
    .a      (a),
    .d      (d),
    .we     (we),
    .rd     (rd),
    .spo    (spo),
    .irq    (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rxdata = b;
    rxnew  = 1'b1;
    @(negedge clk);
    rxnew  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    a  = addr;
    d  = data;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    d  = '0;
    a  = 3'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] exp);
    @(negedge clk);
    a = 3'd0;
    #1;
    chk(tag, spo, exp);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    @(negedge clk);
    a = addr;
    #1;
    chk(tag, spo, exp);
    a = 3'd0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    a = 3'd0;
    #1;
    chk("reset_data", spo, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    rstn = 1'b1;
    reg_chk("reset_status", 3'd1, 32'h0000_0001);
    reg_chk("reset_ctrl", 3'd2, 32'h0);

    // Three bytes in, three out, then an empty read
    push(8'h41); push(8'h42); push(8'h43);
    reg_chk("three_status", 3'd1, 32'h0000_0300);
    rd_chk("rd_41", 32'h141);
    rd_chk("rd_42", 32'h142);
    rd_chk("rd_43", 32'h143);
    rd_chk("rd_empty", 32'h000);
    reg_chk("drained_status", 3'd1, 32'h0000_0001);

    // 17 pushes: the last is dropped and overrun sets
    for (int i = 0; i < 17; i++) push(8'(i));
    reg_chk("ovr_status", 3'd1, 32'h0000_1006);
    for (int i = 0; i < 16; i++) rd_chk("ovr_rd", 32'h100 | 32'(i));
    reg_chk("ovr_drained", 3'd1, 32'h0000_0005);
    wr(3'd1, 32'h4);
    reg_chk("ovr_w1c", 3'd1, 32'h0000_0001);

    // Empty with push and pop together: pop ignored
    @(negedge clk);
    a = 3'd0; rxdata = 8'h99; rxnew = 1'b1; rd = 1'b1;
    @(negedge clk);
    rxnew = 1'b0; rd = 1'b0;
    reg_chk("empty_pushpop", 3'd1, 32'h0000_0100);
    rd_chk("rd_99", 32'h199);

    // Full with push and pop together: both accepted
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    @(negedge clk);
    a = 3'd0; rxdata = 8'hAA; rxnew = 1'b1; rd = 1'b1;
    @(negedge clk);
    rxnew = 1'b0; rd = 1'b0;
    reg_chk("full_pushpop", 3'd1, 32'h0000_1002);
    for (int i = 1; i < 16; i++) rd_chk("fpp_rd", 32'h120 + 32'(i));
    rd_chk("fpp_last_aa", 32'h1AA);
    reg_chk("fpp_drained", 3'd1, 32'h0000_0001);

    // rd held high pops once
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    @(negedge clk);
    a = 3'd0; rd = 1'b1;
    repeat (5) @(negedge clk);
    rd = 1'b0;
    reg_chk("rd_hold_status", 3'd1, 32'h0000_0300);
    rd_chk("hold_rd_51", 32'h151);
    rd_chk("hold_rd_52", 32'h152);
    rd_chk("hold_rd_53", 32'h153);

    // Threshold interrupt
    wr(3'd2, 32'h104);
`ifdef RXFIFO_IRQ_EN
    reg_chk("ctrl_rb", 3'd2, 32'h0000_0104);
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    #1;
    chk("irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    @(negedge clk);
    a = 3'd0; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_fall", {31'b0, irq}, 32'h0);
`else
    reg_chk("ctrl_rb_off", 3'd2, 32'h0);
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    @(negedge clk);
    chk("irq_off", {31'b0, irq}, 32'h0);
    @(negedge clk);
    a = 3'd0; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
`endif
    reg_chk("irq_pop_status", 3'd1, 32'h0000_0300);

    // Flush coincident with a push
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
    reg_chk("six_status", 3'd1, 32'h0000_0600);
    @(negedge clk);
    a = 3'd2; d = 32'h200; we = 1'b1; rxdata = 8'h77; rxnew = 1'b1;
    @(negedge clk);
    we = 1'b0; d = '0; rxnew = 1'b0; a = 3'd0;
    reg_chk("flush_status", 3'd1, 32'h0000_0001);
    reg_chk("flush_ctrl", 3'd2, 32'h0);

    // Flush keeps overrun
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
    reg_chk("pre_flush_ovr", 3'd1, 32'h0000_1006);
    wr(3'd2, 32'h200);
    reg_chk("flush_keeps_ovr", 3'd1, 32'h0000_0005);
    wr(3'd1, 32'h4);

    // Overrun set beats a simultaneous clear
    for (int i = 0; i < 16; i++) push(8'h90 + 8'(i));
    @(negedge clk);
    a = 3'd1; d = 32'h4; we = 1'b1; rxdata = 8'hEE; rxnew = 1'b1;
    @(negedge clk);
    we = 1'b0; d = '0; rxnew = 1'b0;
    reg_chk("set_beats_clr", 3'd1, 32'h0000_1006);

    // Asynchronous reset mid-burst
    @(negedge clk);
    a = 3'd1; rxdata = 8'h55; rxnew = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("async_status", spo, 32'h0000_0001);
    chk("async_irq", {31'b0, irq}, 32'h0);
    rxnew = 1'b0;
    a = 3'd0;
    #1;
    chk("async_data", spo, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    reg_chk("post_reset_ctrl", 3'd2, 32'h0);
    reg_chk("post_reset_status", 3'd1, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
